fnd_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment (FND) display controller for N_DIGITS digits.
- Converts a binary input to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock; no combinational divide.
- Scans digits at a programmable rate, with leading-zero blanking, per-digit decimal points, global blanking and overflow indication.
- Sits between datapath results (adder/counter outputs) and the board FND pins.

---
 rtl/fnd_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed 7-segment scan controller with sequential double-dabble BCD conversion
module fnd_scan_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic [N_DIGITS-1:0] dp_mask,
  input  logic                blank,
  output logic                busy,
  output logic                overflow,
  output logic [N_DIGITS-1:0] fnd_digit,
  output logic [7:0]          fnd_data
);
  localparam int SD  = CLK_HZ / SCAN_HZ < 2 ? 2 : CLK_HZ / SCAN_HZ;
  localparam int SW  = $clog2(SD);
  localparam int IW  = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int NB0 = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int NB  = NB0 > N_DIGITS ? NB0 : N_DIGITS;
  localparam int CW  = $clog2(DATA_W + 1);
  localparam logic [63:0] LIM = 64'(10 ** N_DIGITS);
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} st_t;
  st_t                  st_q, st_d;
  logic [SW-1:0]        scan_q, scan_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]    bin_q, bin_d, pval_q, pval_d, cap;
  logic [4*NB-1:0]      bcd_q, bcd_d, adj;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d, ovc_q, ovc_d, ovf_q, ovf_d;
  logic [N_DIGITS-1:0]  lz;
  logic [3:0]           nib;
  logic [7:0]           seg;
  logic                 z, blk;
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      scan_q <= '0;
      idx_q  <= '0;
      bin_q  <= '0;
      pval_q <= '0;
      bcd_q  <= '0;
      disp_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovc_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      bin_q  <= bin_d;
      pval_q <= pval_d;
      bcd_q  <= bcd_d;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovc_q  <= ovc_d;
      ovf_q  <= ovf_d;
    end
  end
  always_comb begin
    scan_d = scan_q == SW'(SD - 1) ? '0 : scan_q + 1'b1;
    idx_d  = scan_q != SW'(SD - 1) ? idx_q : idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1;
    adj    = bcd_q;
    for (int j = 0; j < NB; j++)
      adj[4*j+:4] = bcd_q[4*j+:4] >= 4'd5 ? bcd_q[4*j+:4] + 4'd3 : bcd_q[4*j+:4];
    cap    = in_valid ? in_data : pval_q;
    st_d   = st_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    pval_d = pval_q;
    ovc_d  = ovc_q;
    ovf_d  = ovf_q;
    disp_d = disp_q;
    if (st_q != IDLE && in_valid) begin
      pend_d = 1'b1;
      pval_d = in_data;
    end
    case (st_q)
      IDLE: if (in_valid || pend_q) begin
        bin_d  = cap;
        bcd_d  = '0;
        cnt_d  = '0;
        pend_d = 1'b0;
        ovc_d  = 64'(cap) >= LIM;
        st_d   = SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[4*NB-2:0], bin_q[DATA_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        st_d  = cnt_q == CW'(DATA_W - 1) ? LOAD : SHIFT;
      end
      LOAD: begin
        disp_d = bcd_q[4*N_DIGITS-1:0];
        ovf_d  = ovc_q;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  // lz[i] is set when digit i and every digit above it are zero
  always_comb begin
    z  = 1'b1;
    lz = '0;
    for (int j = N_DIGITS - 1; j >= 0; j--) begin
      z     = z && disp_q[4*j+:4] == 4'd0;
      lz[j] = z;
    end
    nib       = disp_q[4*idx_q+:4];
    blk       = BLANK_LZ != 0 && idx_q != '0 && lz[idx_q];
    seg       = ovf_q ? 8'hBF : blk ? 8'hFF : SEG[nib];
    fnd_data  = {seg[7] & ~dp_mask[idx_q], seg[6:0]};
    fnd_digit = blank ? '1 : ~(N_DIGITS'(1) << idx_q);
  end
  assign busy     = st_q != IDLE;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed scoreboard bench, two instances differing only in leading-zero blanking
module tb_fnd_scan_ctrl;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, blank = 1'b0;
  logic [13:0] in_data = '0;
  logic [3:0]  dp_mask = '0;
  logic        busy_a, ovf_a, busy_b, ovf_b;
  logic [3:0]  dig_a, dig_b;
  logic [7:0]  dat_a, dat_b;
  int          n_chk = 0, n_fail = 0;
  typedef struct {logic [31:0] a; logic [31:0] b; logic ovf;} frame_t;
  frame_t sb[$];

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.CLK_HZ(4), .SCAN_HZ(1), .N_DIGITS(4), .DATA_W(14), .BLANK_LZ(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .dp_mask(dp_mask),
    .blank(blank), .busy(busy_a), .overflow(ovf_a), .fnd_digit(dig_a), .fnd_data(dat_a));
  fnd_scan_ctrl #(.CLK_HZ(4), .SCAN_HZ(1), .N_DIGITS(4), .DATA_W(14), .BLANK_LZ(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .dp_mask(dp_mask),
    .blank(blank), .busy(busy_b), .overflow(ovf_b), .fnd_digit(dig_b), .fnd_data(dat_b));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(int v, int i, bit lz, bit dpb);
    logic [7:0] codes [10];
    logic [7:0] s;
    int p;
    codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (v >= 10000) s = 8'hBF;
    else if (lz && i > 0 && v < p) s = 8'hFF;
    else s = codes[(v / p) % 10];
    if (dpb) s[7] = 1'b0;
    return s;
  endfunction

  function automatic frame_t mk(int v, logic [3:0] dp);
    frame_t f;
    for (int i = 0; i < 4; i++) begin
      f.a[8*i+:8] = seg_of(v, i, 1'b1, dp[i]);
      f.b[8*i+:8] = seg_of(v, i, 1'b0, dp[i]);
    end
    f.ovf = v >= 10000;
    return f;
  endfunction

  task automatic pulse(int v, bit push);
    @(negedge clk);
    in_data  = 14'(v);
    in_valid = 1'b1;
    if (push) sb.push_back(mk(v, dp_mask));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int c = 0;
    while (busy_a && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  task automatic scan(string tag);
    frame_t f;
    logic [3:0] oh;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    f = sb.pop_front();
    chk({tag, "_ovf_a"}, 32'(ovf_a), 32'(f.ovf));
    chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(f.ovf));
    for (int i = 0; i < 4; i++) begin
      int c = 0;
      oh = ~(4'b0001 << i);
      while (dig_a !== oh && c < 40) begin
        c++;
        @(negedge clk);
      end
      chk($sformatf("%s_dig%0d", tag, i), 32'(dig_a), 32'(oh));
      chk($sformatf("%s_seg_a%0d", tag, i), 32'(dat_a), 32'(f.a[8*i+:8]));
      chk($sformatf("%s_seg_b%0d", tag, i), 32'(dat_b), 32'(f.b[8*i+:8]));
    end
    repeat (4) @(negedge clk);
    chk({tag, "_wrap"}, 32'(dig_a), 32'h0000000E);
  endtask

  initial begin
    int c, chg;
    logic [7:0] prev;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dig", 32'(dig_a), 32'h0000000E);
    chk("rst_data", 32'(dat_a), 32'h000000C0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    sb.push_back(mk(0, 4'b0000));
    scan("rst");
    pulse(1234, 1'b1);
    c = 0;
    while (busy_a && c < 100) begin
      c++;
      @(negedge clk);
    end
    chk("busy_len", 32'(c), 32'd15);
    scan("v1234");
    blank = 1'b1;
    chg = 0;
    prev = dat_a;
    repeat (16) begin
      @(negedge clk);
      chk("blank_dig", 32'(dig_a), 32'h0000000F);
      if (dat_a !== prev) chg++;
      prev = dat_a;
    end
    chk("blank_scan_moves", 32'(chg >= 3), 32'd1);
    blank = 1'b0;
    dp_mask = 4'b0100;
    pulse(7, 1'b1);
    wait_idle("v7");
    scan("v7");
    dp_mask = 4'b0000;
    pulse(16383, 1'b1);
    wait_idle("v16383");
    scan("v16383");
    pulse(42, 1'b1);
    wait_idle("v42");
    scan("v42");
    pulse(12, 1'b0);
    @(negedge clk);
    pulse(34, 1'b0);
    pulse(56, 1'b1);
    wait_idle("pend1");
    @(negedge clk);
    chk("pend_restart", 32'(busy_a), 32'd1);
    wait_idle("pend2");
    scan("v56");
    pulse(1234, 1'b0);
    repeat (5) @(negedge clk);
    pulse(99, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_pend", 32'(busy_a), 32'd0);
    end
    sb.push_back(mk(0, 4'b0000));
    scan("abort");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
